// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide behind a valid/ready handshake, one step per cycle.
module alu_muldiv_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mag_b_q, mag_b_d;
    logic            neg_main_q, neg_main_d;
    logic            neg_rem_q, neg_rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode: operand signedness, magnitudes and special cases.
    logic            accept;
    logic            req_is_div;
    logic            signed_a;
    logic            signed_b;
    logic            sign_a;
    logic            sign_b;
    logic            b_zero;
    logic            div_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] fast_res;

    assign accept     = in_valid && (state_q == S_IDLE) && !flush;
    assign req_is_div = funct3[2];
    assign signed_a   = req_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign signed_b   = req_is_div ? ~funct3[0] : ~funct3[1];
    assign sign_a     = signed_a && rs1[XLEN-1];
    assign sign_b     = signed_b && rs2[XLEN-1];
    assign mag_a      = sign_a ? -rs1 : rs1;
    assign mag_b      = sign_b ? -rs2 : rs2;
    assign b_zero     = (rs2 == '0);
    assign div_ovf    = req_is_div && !funct3[0]
                        && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign fast_hit   = FAST_SPECIAL && req_is_div && (b_zero || div_ovf);

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = funct3[1] ? rs1 : '1;
        end else begin
            fast_res = funct3[1] ? '0 : rs1;
        end
    end

    // One radix-2 step of whichever engine the latched op selects.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_b_q});

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_shift[XLEN-1:0] - mag_b_q : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign correction and half/quotient/remainder selection.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    assign prod_fix = neg_main_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = neg_main_q ? -lo_q : lo_q;
    assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic; flush outranks completion and consumer accept.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = fast_hit ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign result = result_q;

    // Datapath next-state.
    always_comb begin
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mag_b_d    = mag_b_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        if (accept) begin
            op_d       = funct3;
            hi_d       = '0;
            lo_d       = mag_a;
            mag_b_d    = mag_b;
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_main_d = (sign_a ^ sign_b) && !(req_is_div && b_zero);
            neg_rem_d  = sign_a;
            cnt_d      = '0;
            if (fast_hit) begin
                result_d = fast_res;
            end
        end else if (state_q == S_CALC) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == S_FIX) begin
            result_d = fix_res;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the whole datapath is reset so an op killed by rst leaves no
        // residue, and result reads 0 after reset.
        if (rst) begin
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mag_b_q    <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mag_b_q    <= mag_b_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: one instance with the fast special-case
// path enabled and one without, checked against hand-computed values.
module tb_alu_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid_f, in_valid_s;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2;
    logic            flush;
    logic            out_ready;
    logic            in_ready_f, out_valid_f, busy_f;
    logic            in_ready_s, out_valid_s, busy_s;
    logic [XLEN-1:0] result_f, result_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
        .out_valid(out_valid_f), .out_ready(out_ready), .result(result_f),
        .busy(busy_f)
    );

    alu_muldiv_unit #(.XLEN(XLEN), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .busy(busy_s)
    );

    // Wait for in_ready, present a request, return just after the accepting edge.
    task automatic start_op(input bit slow, input logic [2:0] f,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!(slow ? in_ready_s : in_ready_f) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL start_timeout in_ready=0 after 100 cycles, need 1");
        end
        funct3 = f;
        rs1    = a;
        rs2    = b;
        if (slow) in_valid_s = 1'b1;
        else      in_valid_f = 1'b1;
        @(posedge clk);
        #1;
        in_valid_f = 1'b0;
        in_valid_s = 1'b0;
        // Disturb the operands to show they were captured at acceptance.
        funct3 = ~funct3;
        rs1    = ~rs1;
        rs2    = rs2 ^ 32'h5A5A_5A5A;
    endtask

    // Count cycles from acceptance until out_valid; lat=1 means first sample after accept edge.
    task automatic wait_done(input bit slow, output logic [XLEN-1:0] res,
                             output int lat, output bit ready_low);
        lat       = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (slow ? in_ready_s : in_ready_f) ready_low = 1'b0;
        end while (!(slow ? out_valid_s : out_valid_f) && lat < 200);
        res = slow ? result_s : result_f;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready_f, out_valid_f, busy_f, result_f} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_fast ready/valid/busy=%b%b%b result=%h, need 100 / 0",
                     in_ready_f, out_valid_f, busy_f, result_f);
        end
        checks++;
        if ({in_ready_s, out_valid_s, busy_s, result_s} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_slow ready/valid/busy=%b%b%b result=%h, need 100 / 0",
                     in_ready_s, out_valid_s, busy_s, result_s);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        vec_t v[6];
        logic [XLEN-1:0] res;
        int lat;
        bit rl;
        v[0] = '{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1] = '{F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[2] = '{F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3] = '{F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4] = '{F_MULHU,  32'h1234_5678,  32'h0000_0010, 32'h0000_0001};
        v[5] = '{F_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780};
        for (int i = 0; i < 6; i++) begin
            start_op(1'b0, v[i].f, v[i].a, v[i].b);
            wait_done(1'b0, res, lat, rl);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL mul_%0d result=%h, need %h", i, res, v[i].exp);
            end
            checks++;
            if (lat !== XLEN + 2 || !rl) begin
                failures++;
                $display("FAIL mul_lat_%0d latency=%0d in_ready_low=%0d, need %0d / 1",
                         i, lat, rl, XLEN + 2);
            end
            release_op();
        end
    endtask

    task automatic test_div();
        vec_t v[9];
        logic [XLEN-1:0] res;
        int lat;
        bit rl;
        v[0] = '{F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        v[1] = '{F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        v[2] = '{F_DIVU, 32'd100,       32'd7,         32'd14};
        v[3] = '{F_REMU, 32'd100,       32'd7,         32'd2};
        v[4] = '{F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        v[5] = '{F_REM,  32'd7,         32'hFFFF_FFFE, 32'd1};
        v[6] = '{F_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
        // Unsigned form of the overflow pattern is an ordinary divide.
        v[7] = '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[8] = '{F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 9; i++) begin
            start_op(1'b0, v[i].f, v[i].a, v[i].b);
            wait_done(1'b0, res, lat, rl);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL div_%0d result=%h, need %h", i, res, v[i].exp);
            end
            checks++;
            if (lat !== XLEN + 2 || !rl) begin
                failures++;
                $display("FAIL div_lat_%0d latency=%0d in_ready_low=%0d, need %0d / 1",
                         i, lat, rl, XLEN + 2);
            end
            release_op();
        end
    endtask

    task automatic test_special();
        vec_t v[8];
        logic [XLEN-1:0] res;
        int lat;
        int exp_lat;
        bit rl;
        v[0] = '{F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{F_REM,  32'd5,         32'd0,         32'd5};
        v[2] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[4] = '{F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[5] = '{F_REMU, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        v[6] = '{F_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        v[7] = '{F_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        for (int s = 0; s < 2; s++) begin
            exp_lat = (s == 0) ? 1 : XLEN + 2;
            for (int i = 0; i < 8; i++) begin
                start_op(s[0], v[i].f, v[i].a, v[i].b);
                wait_done(s[0], res, lat, rl);
                checks++;
                if (res !== v[i].exp) begin
                    failures++;
                    $display("FAIL special_%0d_slow%0d result=%h, need %h",
                             i, s, res, v[i].exp);
                end
                checks++;
                if (lat !== exp_lat) begin
                    failures++;
                    $display("FAIL special_lat_%0d_slow%0d latency=%0d, need %0d",
                             i, s, lat, exp_lat);
                end
                release_op();
            end
        end
    endtask

    task automatic test_hold();
        logic [XLEN-1:0] res;
        int lat;
        bit rl;
        int bad = 0;
        start_op(1'b0, F_MUL, 32'd6, 32'd7);
        wait_done(1'b0, res, lat, rl);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_f !== 1'b1 || result_f !== 32'd42) begin
                failures++;
                bad++;
                $display("FAIL hold_%0d out_valid=%b result=%h, need 1 / 0000002a",
                         i, out_valid_f, result_f);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready_f !== 1'b1 || out_valid_f !== 1'b0) begin
            failures++;
            $display("FAIL hold_exit in_ready=%b out_valid=%b, need 1 / 0",
                     in_ready_f, out_valid_f);
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] res;
        int lat;
        bit rl;
        int seen = 0;
        // Kill at iteration 5 of CALC.
        start_op(1'b0, F_MUL, 32'h0000_1234, 32'h0000_5678);
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready_f !== 1'b1 || out_valid_f !== 1'b0 || busy_f !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc ready/valid/busy=%b%b%b, need 100",
                     in_ready_f, out_valid_f, busy_f);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid_f) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL flush_no_result out_valid high %0d cycles, need 0", seen);
        end
        start_op(1'b0, F_MULHU, 32'h1234_5678, 32'h0000_0010);
        wait_done(1'b0, res, lat, rl);
        checks++;
        if (res !== 32'h1 || lat !== XLEN + 2) begin
            failures++;
            $display("FAIL flush_next result=%h latency=%0d, need 00000001 / %0d",
                     res, lat, XLEN + 2);
        end
        // Flush in DONE discards the held result.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready_f !== 1'b1 || out_valid_f !== 1'b0) begin
            failures++;
            $display("FAIL flush_done in_ready=%b out_valid=%b, need 1 / 0",
                     in_ready_f, out_valid_f);
        end
        // Request and flush together in IDLE: not accepted.
        in_valid_f = 1'b1;
        funct3     = F_DIVU;
        rs1        = 32'd9;
        rs2        = 32'd3;
        flush      = 1'b1;
        @(negedge clk);
        in_valid_f = 1'b0;
        flush      = 1'b0;
        checks++;
        if (busy_f !== 1'b0 || in_ready_f !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle busy=%b in_ready=%b, need 0 / 1", busy_f, in_ready_f);
        end
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] res;
        int lat;
        bit rl;
        start_op(1'b0, F_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_f, out_valid_f, busy_f, result_f} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid ready/valid/busy=%b%b%b result=%h, need 100 / 0",
                     in_ready_f, out_valid_f, busy_f, result_f);
        end
        rst = 1'b0;
        start_op(1'b0, F_DIVU, 32'd100, 32'd7);
        wait_done(1'b0, res, lat, rl);
        checks++;
        if (res !== 32'd14 || lat !== XLEN + 2) begin
            failures++;
            $display("FAIL reset_next result=%h latency=%0d, need 0000000e / %0d",
                     res, lat, XLEN + 2);
        end
        release_op();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid_f = 1'b0;
        in_valid_s = 1'b0;
        funct3     = 3'b000;
        rs1        = '0;
        rs2        = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
